// File: rtl/slave_pkg.sv
// Shared types and widths for the slave memory responder.
// The optional SLV_STATS_EN build adds no package content.
package slave_pkg;

  localparam int LAT_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/slave_mem_array.sv
// Register-file memory: synchronous write, registered read.
// Every word is filled with RST_FILL while rst is low.
module slave_mem_array
  import slave_pkg::*;
#(
  parameter int                 AW       = 4,
  parameter logic [DATA_W-1:0]  RST_FILL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_FILL;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      // rdata is zero outside the single read-ack cycle
      rdata <= re ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/slave_mem_resp.sv
// Bus slave: captures a request, waits LAT cycles, acks from a small memory.
// Define SLV_STATS_EN to add the wr_cnt/rd_cnt transaction counters.
module slave_mem_resp
  import slave_pkg::*;
#(
  parameter int                 AW       = 4,
  parameter int                 LAT      = 2,
  parameter logic [DATA_W-1:0]  RST_FILL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
`ifdef SLV_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt
`endif
);

  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(LAT);

  state_t            state;
  state_t            state_nx;
  logic [LAT_W-1:0]  cnt;
  logic [LAT_W-1:0]  cnt_nx;
  logic              cap;
  logic              cmd_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_ack;
  logic              unused;

  assign unused = ^addr[31:AW];
  assign in_ack = (state == ACK);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          cap      = 1'b1;
          cnt_nx   = LAT_V;
          state_nx = (LAT_V != '0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == LAT_W'(1)) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = HOLD;
      end
      HOLD: begin
        if (!req) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // ack and rdata are registered together off the ACK cycle
      ack   <= in_ack;
      if (cap) begin
        cmd_q   <= cmd;
        idx_q   <= addr[AW-1:0];
        wdata_q <= wdata;
      end
    end
  end

  slave_mem_array #(
    .AW       (AW),
    .RST_FILL (RST_FILL)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (in_ack & cmd_q),
    .re    (in_ack & ~cmd_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

`ifdef SLV_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (in_ack) begin
      if (cmd_q) begin
        wr_cnt <= wr_cnt + 16'd1;
      end else begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/slave_mem_resp.md
Name: slave_mem_resp

Overview:
- Downstream responder for the bus master: consumes req/cmd/addr/wdata and returns ack/rdata.
- Backed by a small register-file memory, with a programmable number of wait states before ack.
- One instance per slave port; several masters reach it through the interconnect with the same 4-phase-style handshake.
- Provides deterministic read-back so master-side tests can check data end to end.

Parameters:
- AW, 4, index width; memory depth 2**AW words of 32 bits.
- LAT, 2, wait cycles between request capture and ack; legal range 0..15.
- RST_FILL, 32'h0, value loaded into every memory word on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request from master; held high until ack has been seen and released.
- cmd  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address; only addr[AW-1:0] used, upper bits ignored (aliasing).
- wdata  in  32  write data; sampled with req when cmd = 1.
- ack  out  1  one-cycle acknowledge pulse.
- rdata  out  32  read data; valid in the ack cycle of a read, 0 otherwise.

Behaviour:
- Reset (rst = 0, asynchronous):
  - ack = 0, rdata = 0, state = IDLE, wait counter = 0.
  - All memory words = RST_FILL.
  - Deassertion is synchronous to clk; the first capture is possible on the first edge after release.
- States: IDLE, WAIT, ACK, HOLD.
- IDLE: on req = 1, register cmd, addr[AW-1:0] and wdata, load counter = LAT.
  - Next state is WAIT if LAT > 0, otherwise ACK.
  - Inputs are captured only in IDLE; changes to cmd/addr/wdata after capture are ignored.
- WAIT: decrement the counter each cycle; go to ACK when it reaches 1 (exactly LAT cycles in WAIT).
- ACK: ack = 1 for exactly one cycle.
  - Write: memory[idx] <= captured wdata at the end of this cycle; rdata = 0.
  - Read: rdata = memory[idx], registered, so it is valid during the ack = 1 cycle.
  - Next state is HOLD.
- HOLD: ack = 0, rdata = 0; stay until req = 0, then go to IDLE.
  - A req still high after ack never re-triggers a transaction.
- Latency: ack rises LAT+1 edges after the edge on which req was captured in IDLE.
- If req drops during WAIT, the transaction still completes (ack is issued); the state then goes ACK -> HOLD -> IDLE immediately, since req is already 0.
- Read of the word written by the immediately preceding transaction returns the new data (the write commits in its ACK cycle; the next capture is at least 2 cycles later).
- Reset mid-transaction: the transaction is aborted with no memory update, ack = 0, state = IDLE.
- Width rules: index = addr[AW-1:0] unsigned; no range error, aliasing is defined behaviour.

Optional Feature:
- Macro: SLV_STATS_EN.
- Defined:
  - Adds outputs wr_cnt[15:0] and rd_cnt[15:0], reset to 0.
  - Each counter increments by 1 in every ACK cycle of its transaction type and wraps 0xFFFF -> 0x0000.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package slave_pkg holds:
  - state enum: IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2, HOLD = 2'd3.
  - LAT_W = 4 (counter width).
  - DATA_W = 32.
- One sub-module, slave_mem_array:
  - 2**AW x 32 register file with synchronous write and registered read.
  - Async active-low reset fill to RST_FILL.
- The FSM and counter stay in the top module.

Test Plan:
1. LAT = 2, write addr 0x5, wdata 0x00000345, req held -> ack = 1 on the 3rd edge after capture for one cycle; no second ack while req stays high; memory[5] = 0x345.
2. Then read addr 0x80000015 (aliases index 5) -> rdata = 0x00000345 only in the ack cycle, 0 before and after.
3. LAT = 0, back-to-back read/write/read with the master dropping req one cycle after ack -> ack on the 1st edge after each capture; the read after a write to the same index returns the written value.
4. Assert rst during WAIT of a write to index 3 with wdata 0xABCD -> ack stays 0, memory[3] = RST_FILL, state IDLE; the next read of index 3 returns RST_FILL.
5. req pulsed high for 1 cycle only (LAT = 3) -> exactly one ack 4 edges later; FSM returns to IDLE on the next edge.
6. SLV_STATS_EN defined: 3 writes + 2 reads -> wr_cnt = 3, rd_cnt = 2; preload wr_cnt = 0xFFFF via forced stimulus, then one write -> 0x0000.
